// File: rtl/heat_wash_sequencer.sv
// rtl/heat_wash_sequencer.sv - heater start/temp_ready initiator with timed wash phase
//
// Purpose: requests heating, waits for temp_ready with a timeout, runs a timed wash
// with heat held, then reports phase_done (one clock) or heat_fault (held until cleared).
//
// Optional feature macro: HEAT_RETRY_EN (one retry of the heat phase before faulting).
//
// Ports:
//   clk_i          system clock, rising edge
//   reset_i        asynchronous active-high reset
//   cycle_go_i     start request, sampled in IDLE only
//   cycle_abort_i  return to IDLE from any state except FAULT
//   fault_clear_i  leave FAULT to IDLE
//   temp_ready_i   heater at target temperature
//   heat_start_o   heater enable
//   motor_on_o     wash motor enable
//   phase_done_o   one-clock pulse on wash completion
//   heat_fault_o   high while in FAULT
//   phase_state_o  state encoding: IDLE=0 HEAT=1 WASH=2 DONE=3 FAULT=4 RETRY=5

module heat_wash_sequencer #(
    parameter int HEAT_TIMEOUT = 32,
    parameter int WASH_CYCLES  = 20
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       cycle_go_i,
    input  logic       cycle_abort_i,
    input  logic       fault_clear_i,
    input  logic       temp_ready_i,
    output logic       heat_start_o,
    output logic       motor_on_o,
    output logic       phase_done_o,
    output logic       heat_fault_o,
    output logic [2:0] phase_state_o
);

    localparam int CMAX = (HEAT_TIMEOUT > WASH_CYCLES) ? HEAT_TIMEOUT : WASH_CYCLES;
    localparam int CW   = (CMAX > 2) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] HEAT_LAST = CW'(HEAT_TIMEOUT - 1);
    localparam logic [CW-1:0] WASH_LAST = CW'(WASH_CYCLES - 1);

`ifdef HEAT_RETRY_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HEAT  = 3'd1,
        S_WASH  = 3'd2,
        S_DONE  = 3'd3,
        S_FAULT = 3'd4,
        S_RETRY = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HEAT  = 3'd1,
        S_WASH  = 3'd2,
        S_DONE  = 3'd3,
        S_FAULT = 3'd4
    } state_t;
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            heat_start_q, heat_start_d;
    logic            motor_on_q, motor_on_d;
    logic            phase_done_q, phase_done_d;
    logic            heat_fault_q, heat_fault_d;
`ifdef HEAT_RETRY_EN
    logic            retry_used_q, retry_used_d;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            heat_start_q <= 1'b0;
            motor_on_q   <= 1'b0;
            phase_done_q <= 1'b0;
            heat_fault_q <= 1'b0;
`ifdef HEAT_RETRY_EN
            retry_used_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            heat_start_q <= heat_start_d;
            motor_on_q   <= motor_on_d;
            phase_done_q <= phase_done_d;
            heat_fault_q <= heat_fault_d;
`ifdef HEAT_RETRY_EN
            retry_used_q <= retry_used_d;
`endif
        end
    end

    // The shared counter only advances while staying in HEAT or WASH; every state
    // change clears it, so each phase starts counting from zero on entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
`ifdef HEAT_RETRY_EN
        retry_used_d = retry_used_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cycle_go_i && !cycle_abort_i) begin
                    state_d = S_HEAT;
                end
            end
            S_HEAT: begin
                if (cycle_abort_i) begin
                    state_d = S_IDLE;
                end else if (temp_ready_i) begin
                    state_d = S_WASH;
                end else if (cnt_q == HEAT_LAST) begin
`ifdef HEAT_RETRY_EN
                    if (!retry_used_q) begin
                        state_d      = S_RETRY;
                        retry_used_d = 1'b1;
                    end else begin
                        state_d = S_FAULT;
                    end
`else
                    state_d = S_FAULT;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WASH: begin
                // Heat loss outranks completion on the final wash clock.
                if (cycle_abort_i) begin
                    state_d = S_IDLE;
                end else if (!temp_ready_i) begin
                    state_d = S_FAULT;
                end else if (cnt_q == WASH_LAST) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_FAULT: begin
                if (fault_clear_i) begin
                    state_d = S_IDLE;
                end
            end
`ifdef HEAT_RETRY_EN
            S_RETRY: begin
                // One clock with heat_start low lets the heater drop temp_ready.
                if (cycle_abort_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HEAT;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef HEAT_RETRY_EN
        if (state_d == S_IDLE) begin
            retry_used_d = 1'b0;
        end
`endif
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        heat_start_d = (state_d == S_HEAT) || (state_d == S_WASH);
        motor_on_d   = (state_d == S_WASH);
        phase_done_d = (state_d == S_DONE);
        heat_fault_d = (state_d == S_FAULT);
    end

    assign heat_start_o  = heat_start_q;
    assign motor_on_o    = motor_on_q;
    assign phase_done_o  = phase_done_q;
    assign heat_fault_o  = heat_fault_q;
    assign phase_state_o = state_q;

endmodule
